// File: rtl/mfp_accel_spi_reader.sv
// SPI mode-0 master for the ADXL362: one power-up config write, then periodic 6-byte XYZ reads.
// Each completed read updates x/y/z together and pulses acc_valid for one cycle.
module mfp_accel_spi_reader #(
  parameter int unsigned CLK_DIV        = 25,
  parameter int unsigned STARTUP_CYCLES = 250000,
  parameter int unsigned SAMPLE_CYCLES  = 500000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic [11:0] x_acc,
  output logic [11:0] y_acc,
  output logic [11:0] z_acc,
  output logic        acc_valid,
  output logic        cfg_done
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned StW  = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned TmW  = $clog2(SAMPLE_CYCLES);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [StW-1:0]  StLast  = StW'(STARTUP_CYCLES - 1);
  localparam logic [TmW-1:0]  TmLast  = TmW'(SAMPLE_CYCLES - 1);

  if (CLK_DIV < 2 || SAMPLE_CYCLES < 20 * CLK_DIV * 8) begin : gen_param_check
    $error("mfp_accel_spi_reader: CLK_DIV must be >= 2 and SAMPLE_CYCLES >= 160*CLK_DIV");
  end

  typedef enum logic [2:0] {StStartup, StCfg, StWait, StRead, StLatch} state_e;
  typedef enum logic [1:0] {PhLow, PhHigh, PhTrail} phase_e;

  function automatic logic [7:0] tx_byte(input state_e st, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (st == StCfg) begin
      case (idx)
        3'd0:    b = 8'h0A;
        3'd1:    b = 8'h2D;
        3'd2:    b = 8'h02;
        default: b = 8'h00;
      endcase
    end else if (idx == 3'd0) begin
      b = 8'h0B;
    end else if (idx == 3'd1) begin
      b = 8'h0E;
    end
    return b;
  endfunction

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [StW-1:0]  startup_q, startup_d;
  logic [TmW-1:0]  timer_q, timer_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            cfg_done_q, cfg_done_d;
  logic [47:0]     rx_buf_q, rx_buf_d;
  logic [11:0]     x_q, x_d, y_q, y_d, z_q, z_d;

  logic       half_end, last_bit, timer_hit, start;
  logic [7:0] tx_nxt, tx_first;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    div_d      = div_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    startup_d  = startup_q;
    timer_d    = timer_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    cfg_done_d = cfg_done_q;
    rx_buf_d   = rx_buf_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    tx_nxt     = 8'h00;
    tx_first   = 8'h00;
    start      = 1'b0;

    half_end  = (div_q == DivLast);
    last_bit  = (bit_q == 3'd7) && ((state_q == StCfg) ? (byte_q == 3'd2) : (byte_q == 3'd7));
    timer_hit = (timer_q == TmLast);

    // Timer free-runs once configured so read starts stay exactly SAMPLE_CYCLES apart.
    if (cfg_done_q) begin
      timer_d = timer_hit ? '0 : timer_q + TmW'(1);
    end

    unique case (state_q)
      StStartup: begin
        if (startup_q == StLast) begin
          state_d = StCfg;
          start   = 1'b1;
        end else begin
          startup_d = startup_q + StW'(1);
        end
      end
      StWait: begin
        if (timer_hit) begin
          state_d = StRead;
          start   = 1'b1;
        end
      end
      StCfg, StRead: begin
        div_d = half_end ? '0 : div_q + DivW'(1);
        if (half_end) begin
          unique case (phase_q)
            PhLow: begin
              sclk_d   = 1'b1;
              phase_d  = PhHigh;
              // Only the last 48 bits survive: XL..ZH of a read.
              rx_buf_d = {rx_buf_q[46:0], spi_miso};
            end
            PhHigh: begin
              sclk_d = 1'b0;
              if (last_bit) begin
                phase_d = PhTrail;
              end else begin
                bit_d   = bit_q + 3'd1;
                byte_d  = (bit_q == 3'd7) ? byte_q + 3'd1 : byte_q;
                tx_nxt  = tx_byte(state_q, byte_d);
                mosi_d  = tx_nxt[~bit_d];
                phase_d = PhLow;
              end
            end
            default: begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              if (state_q == StCfg) begin
                cfg_done_d = 1'b1;
                timer_d    = '0;
                state_d    = StWait;
              end else begin
                x_d     = {rx_buf_q[35:32], rx_buf_q[47:40]};
                y_d     = {rx_buf_q[19:16], rx_buf_q[31:24]};
                z_d     = {rx_buf_q[3:0],   rx_buf_q[15:8]};
                state_d = StLatch;
              end
            end
          endcase
        end
      end
      StLatch: state_d = StWait;
      default: state_d = StStartup;
    endcase

    if (start) begin
      tx_first = tx_byte(state_d, 3'd0);
      cs_n_d   = 1'b0;
      sclk_d   = 1'b0;
      phase_d  = PhLow;
      div_d    = '0;
      bit_d    = 3'd0;
      byte_d   = 3'd0;
      mosi_d   = tx_first[7];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StStartup;
      phase_q    <= PhLow;
      div_q      <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 3'd0;
      startup_q  <= '0;
      timer_q    <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      rx_buf_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      startup_q  <= startup_d;
      timer_q    <= timer_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      cfg_done_q <= cfg_done_d;
      rx_buf_q   <= rx_buf_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
    end
  end

  assign spi_sclk  = sclk_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
  assign cfg_done  = cfg_done_q;
  assign x_acc     = x_q;
  assign y_acc     = y_q;
  assign z_acc     = z_q;
  assign acc_valid = (state_q == StLatch);

endmodule

// File: tb/tb_mfp_accel_spi_reader.sv
// Bench for mfp_accel_spi_reader: SPI slave model plus a cycle-indexed timing model of the
// expected pin waveform and sample outputs, with randomized sensor data.
module tb_mfp_accel_spi_reader;

  localparam int CD     = 4;
  localparam int ST     = 100;
  localparam int SP     = 2000;
  localparam int CFG_LEN = 16 * CD * 3 + CD;
  localparam int RD_LEN  = 16 * CD * 8 + CD;
  localparam int E       = ST + CFG_LEN;

  logic        HCLK;
  logic        HRESETn;
  logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic [11:0] x_acc, y_acc, z_acc;
  logic        acc_valid, cfg_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc;

  logic [7:0] sens [6];
  logic [7:0] last_snap [6];

  mfp_accel_spi_reader #(
    .CLK_DIV        (CD),
    .STARTUP_CYCLES (ST),
    .SAMPLE_CYCLES  (SP)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_cs_n  (spi_cs_n),
    .x_acc     (x_acc),
    .y_acc     (y_acc),
    .z_acc     (z_acc),
    .acc_valid (acc_valid),
    .cfg_done  (cfg_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] cfg_byte(input int i);
    case (i)
      0:       return 8'h0A;
      1:       return 8'h2D;
      default: return 8'h02;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(input int i);
    case (i)
      0:       return 8'h0B;
      1:       return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  // Expected pins after posedge n (counted from reset release), from the transaction schedule.
  function automatic void exp_pins(input int n, output bit cs, output bit sck,
                                   output bit mchk, output bit mo);
    int s, nb, o, k;
    bit act;
    logic [7:0] b;
    cs = 1; sck = 0; mchk = 0; mo = 0; act = 0; s = 0; nb = 0;
    if (n >= ST && n < E) begin
      s = ST; nb = 3; act = 1;
    end else if (n >= E + SP) begin
      s = E + ((n - E) / SP) * SP; nb = 8; act = (n - s) < RD_LEN;
    end
    if (act) begin
      o  = n - s;
      cs = 0;
      if (o >= CD && o < 16 * CD * nb) sck = ((o - CD) % (2 * CD)) < CD;
      if (o < 16 * CD * nb) begin
        k    = o / (2 * CD);
        b    = (nb == 3) ? cfg_byte(k / 8) : rd_byte(k / 8);
        mchk = 1;
        mo   = b[7 - (k % 8)];
      end
    end
  endfunction

  // SPI slave: snapshots the sensor registers at cs_n fall, drives MISO on SCLK falls,
  // captures MOSI on SCLK rises and checks each complete transaction's command bytes.
  initial begin
    logic [63:0] miso_sh, mosi_cap;
    logic [7:0]  snap_b [6];
    logic [15:0] junk;
    int  rises, xfer_idx;
    bit  cs_prev, sck_prev, in_xfer;
    spi_miso = 1'b0; cs_prev = 1; sck_prev = 0; xfer_idx = 0; in_xfer = 0;
    rises = 0; miso_sh = '0; mosi_cap = '0;
    forever begin
      @(spi_cs_n or spi_sclk or HRESETn);
      if (!HRESETn) begin
        xfer_idx = 0; in_xfer = 0; spi_miso = 1'b0;
      end else begin
        if (cs_prev && !spi_cs_n) begin
          for (int i = 0; i < 6; i++) snap_b[i] = sens[i];
          junk     = 16'($urandom);
          miso_sh  = {junk, snap_b[0], snap_b[1], snap_b[2], snap_b[3], snap_b[4], snap_b[5]};
          spi_miso = miso_sh[63];
          rises = 0; mosi_cap = '0; in_xfer = 1;
        end else if (!cs_prev && spi_cs_n && in_xfer) begin
          in_xfer = 0;
          if (xfer_idx == 0) begin
            check("cfg_sclk_rises", rises, 24);
            check("cfg_mosi_bytes", mosi_cap, 64'h0A2D02);
          end else begin
            check("read_sclk_rises", rises, 64);
            check("read_mosi_bytes", mosi_cap, 64'h0B0E_0000_0000_0000);
            for (int i = 0; i < 6; i++) last_snap[i] = snap_b[i];
          end
          xfer_idx++;
        end
        if (!spi_cs_n && !sck_prev && spi_sclk) begin
          mosi_cap = {mosi_cap[62:0], spi_mosi};
          rises++;
        end
        if (!spi_cs_n && sck_prev && !spi_sclk) begin
          miso_sh  = miso_sh << 1;
          spi_miso = miso_sh[63];
        end
      end
      cs_prev = spi_cs_n; sck_prev = spi_sclk;
    end
  end

  // Every-cycle comparison of pins, flags and samples against the schedule model.
  initial begin
    logic [11:0] mx, my, mz;
    bit cs, sck, mchk, mo, av;
    mx = '0; my = '0; mz = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        mx = '0; my = '0; mz = '0;
      end else begin
        exp_pins(cyc, cs, sck, mchk, mo);
        av = (cyc >= E + SP) && (((cyc - E) % SP) == RD_LEN);
        if (av) begin
          mx = {last_snap[1][3:0], last_snap[0]};
          my = {last_snap[3][3:0], last_snap[2]};
          mz = {last_snap[5][3:0], last_snap[4]};
        end
        check("pins_flags_samples",
              {spi_cs_n, spi_sclk, cfg_done, acc_valid, x_acc, y_acc, z_acc},
              {cs, sck, (cyc >= E), av, mx, my, mz});
        if (mchk) check("mosi_bit", spi_mosi, mo);
      end
    end
  end

  // Config start cycle and read-to-read spacing.
  initial begin
    int last_fall;
    last_fall = 0;
    forever begin
      @(negedge spi_cs_n);
      #1;
      if (HRESETn) begin
        if (cyc < E) check("cfg_start_cycle", cyc, ST);
        else if (last_fall > E) check("read_period", cyc - last_fall, SP);
        last_fall = cyc;
      end
    end
  end

  task automatic wait_read_start(input int limit, output bit ok);
    bit prev;
    ok = 0;
    prev = spi_cs_n;
    for (int i = 0; i < limit; i++) begin
      @(negedge HCLK);
      if (prev && !spi_cs_n) begin
        ok = 1;
        break;
      end
      prev = spi_cs_n;
    end
  endtask

  task automatic wait_acc_valid(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge HCLK);
      if (acc_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    HRESETn = 1'b0;
    for (int i = 0; i < 6; i++) sens[i] = 8'h00;
    for (int i = 0; i < 6; i++) last_snap[i] = 8'h00;
    repeat (5) @(negedge HCLK);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_xyz", {x_acc, y_acc, z_acc}, 0);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_cfg_done", cfg_done, 0);

    sens[0] = 8'h34; sens[1] = 8'hF1; sens[2] = 8'hF0;
    sens[3] = 8'hFF; sens[4] = 8'h00; sens[5] = 8'h07;
    @(negedge HCLK);
    HRESETn = 1'b1;

    wait_acc_valid(3000, ok);
    check("first_sample_seen", ok, 1);
    if (ok) begin
      check("first_x", x_acc, 12'h134);
      check("first_y", y_acc, 12'hFF0);
      check("first_z", z_acc, 12'h700);
      @(negedge HCLK);
      check("acc_valid_one_cycle", acc_valid, 0);
    end

    // Random data, with the sensor registers also changing mid-transaction.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) sens[i] = 8'($urandom);
      wait_read_start(2500, ok);
      check("read_start_seen", ok, 1);
      repeat ($urandom_range(1, 500)) @(negedge HCLK);
      for (int i = 0; i < 6; i++) sens[i] = 8'($urandom);
    end

    // Reset during the fourth byte of a read, while SCLK is high.
    wait_read_start(2500, ok);
    check("read_start_before_reset", ok, 1);
    repeat (16 * CD * 3 + CD + 2) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_xyz", {x_acc, y_acc, z_acc}, 0);
    check("abort_cfg_done", cfg_done, 0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    wait_acc_valid(3000, ok);
    check("sample_after_reset", ok, 1);
    repeat (50) @(negedge HCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
